layer_stream_serializer: RTL and testbench

//  Parametrised parallel-to-serial bridge between NN layers. Captures a full layer output vector
//  (NUM_ELEM elements) and streams it LANES elements per beat to the next layer / AXI-stream sink.

---
 rtl/nn_stream_pkg.sv | 19 +
 rtl/vec_fifo.sv | 65 ++++++
 rtl/layer_stream_serializer.sv | 112 +++++++++++
 tb/tb_layer_stream_serializer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nn_stream_pkg
// Description : Shared types and helpers for NN layer streaming blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package nn_stream_pkg;

    localparam int DROP_CNT_W = 16;
    localparam int ELEM_W     = 16;

    typedef logic [ELEM_W-1:0] elem_t;

    function automatic int beats(input int num_elem, input int lanes);
        return num_elem / lanes;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vec_fifo.sv
`default_nettype none
// ============================================================================
// Module      : vec_fifo
// Description : Small whole-vector FIFO with occupancy count; head is read
//               combinationally from storage.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count
);

    localparam int                 c_ptr_w    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_last_ptr) ? '0 : p + c_ptr_w'(1);
    endfunction

    // Write-while-full only happens together with a head pop, so the slot
    // being overwritten is the one leaving on this same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (wr_en) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (rd_en) r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/layer_stream_serializer.sv
`default_nettype none
// ============================================================================
// Module      : layer_stream_serializer
// Description : Buffers whole layer output vectors and streams them LANES
//               elements per beat with backpressure, last marker and drop count.
// Revision    : 1.0 - initial release
// ============================================================================
module layer_stream_serializer
    import nn_stream_pkg::*;
#(
    parameter int NUM_ELEM   = 30,
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 1,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                           s_axi_aclk,
    input  logic                           s_axi_aresetn,
    input  logic                           soft_reset,
    input  logic                           in_valid,
    input  logic [NUM_ELEM*DATA_WIDTH-1:0] in_data,
    output logic                           in_ready,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [LANES*DATA_WIDTH-1:0]    out_data,
    output logic                           out_last,
    output logic                           overflow,
    output logic [DROP_CNT_W-1:0]          drop_count
);

    localparam int                  c_beats     = beats(NUM_ELEM, LANES);
    localparam int                  c_beat_w    = (c_beats > 1) ? $clog2(c_beats) : 1;
    localparam int                  c_beat_bits = LANES * DATA_WIDTH;
    localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(c_beats - 1);
    localparam int                  c_cnt_w     = $clog2(BUF_DEPTH + 1);
    localparam logic [c_cnt_w-1:0]  c_depth     = c_cnt_w'(BUF_DEPTH);

    generate
        if ((NUM_ELEM % LANES) != 0) begin : g_bad_lanes
            $error("layer_stream_serializer: LANES must divide NUM_ELEM");
        end
        if ((BUF_DEPTH < 1) || (BUF_DEPTH > 2)) begin : g_bad_depth
            $error("layer_stream_serializer: BUF_DEPTH must be 1 or 2");
        end
    endgenerate

    logic [NUM_ELEM*DATA_WIDTH-1:0] w_head;
    logic [c_cnt_w-1:0]             w_count;
    logic                           w_out_valid;
    logic                           w_last;
    logic                           w_pop;
    logic                           w_in_ready;
    logic                           w_push;
    logic                           w_drop;
    logic [c_beat_w-1:0]            r_beat;
    logic                           r_overflow;
    logic [DROP_CNT_W-1:0]          r_drop_count;

    assign w_out_valid = (w_count != '0);
    assign w_last      = w_out_valid && (r_beat == c_last_beat);
    assign w_pop       = w_out_valid && out_ready && w_last;
    assign w_in_ready  = (w_count < c_depth) || w_pop;
    assign w_push      = in_valid && w_in_ready;
    assign w_drop      = in_valid && !w_in_ready;

    vec_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (NUM_ELEM * DATA_WIDTH),
        .CNT_W (c_cnt_w)
    ) u_vec_fifo (
        .clk     (s_axi_aclk),
        .rst_n   (s_axi_aresetn),
        .clr     (soft_reset),
        .wr_en   (w_push),
        .wr_data (in_data),
        .rd_en   (w_pop),
        .rd_data (w_head),
        .count   (w_count)
    );

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_beat <= '0;
        end else if (soft_reset) begin
            r_beat <= '0;
        end else if (w_out_valid && out_ready) begin
            r_beat <= w_last ? '0 : r_beat + c_beat_w'(1);
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (soft_reset) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != '1) r_drop_count <= r_drop_count + DROP_CNT_W'(1);
        end
    end

    // Beat data is forced to zero when idle so reset shows a clean bus.
    assign out_data   = w_out_valid ? w_head[int'(r_beat)*c_beat_bits +: c_beat_bits] : '0;
    assign out_valid  = w_out_valid;
    assign out_last   = w_last;
    assign in_ready   = w_in_ready;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_layer_stream_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_layer_stream_serializer
// Description : Directed self-checking bench for layer_stream_serializer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_stream_serializer;
    import nn_stream_pkg::*;

    logic s_axi_aclk = 1'b0;
    always #5 s_axi_aclk = ~s_axi_aclk;

    logic s_axi_aresetn;
    logic soft_reset;

    // Instance A: 4 elements, 1 lane
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_overflow;
    logic [63:0] a_in_data;
    logic [15:0] a_out_data, a_drop_count;
    // Instance B: 4 elements, 2 lanes
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_overflow;
    logic [63:0] b_in_data;
    logic [31:0] b_out_data;
    logic [15:0] b_drop_count;
    // Instance C: 30 elements, 1 lane
    logic         c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_last, c_overflow;
    logic [479:0] c_in_data;
    logic [15:0]  c_out_data, c_drop_count;

    layer_stream_serializer #(.NUM_ELEM(4), .DATA_WIDTH(16), .LANES(1), .BUF_DEPTH(2)) dut_a (
        .s_axi_aclk(s_axi_aclk), .s_axi_aresetn(s_axi_aresetn), .soft_reset(soft_reset),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_last(a_out_last), .overflow(a_overflow), .drop_count(a_drop_count));

    layer_stream_serializer #(.NUM_ELEM(4), .DATA_WIDTH(16), .LANES(2), .BUF_DEPTH(2)) dut_b (
        .s_axi_aclk(s_axi_aclk), .s_axi_aresetn(s_axi_aresetn), .soft_reset(soft_reset),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_last(b_out_last), .overflow(b_overflow), .drop_count(b_drop_count));

    layer_stream_serializer #(.NUM_ELEM(30), .DATA_WIDTH(16), .LANES(1), .BUF_DEPTH(2)) dut_c (
        .s_axi_aclk(s_axi_aclk), .s_axi_aresetn(s_axi_aresetn), .soft_reset(soft_reset),
        .in_valid(c_in_valid), .in_data(c_in_data), .in_ready(c_in_ready),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .out_last(c_out_last), .overflow(c_overflow), .drop_count(c_drop_count));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge s_axi_aclk);
        #1;
    endtask

    function automatic logic [63:0] vec4(input elem_t e3, input elem_t e2, input elem_t e1, input elem_t e0);
        return {e3, e2, e1, e0};
    endfunction

    localparam logic [63:0] V1 = 64'h0014_0013_0012_0011;
    localparam logic [63:0] V2 = 64'h0024_0023_0022_0021;
    localparam logic [63:0] V3 = 64'h0034_0033_0032_0031;

    initial begin
        int          idx;
        int          cyc;
        logic [31:0] pat;
        logic [15:0] exp_e;

        s_axi_aresetn = 1'b0;
        soft_reset    = 1'b0;
        a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
        b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
        c_in_valid = 0; c_in_data = '0; c_out_ready = 0;
        for (int e = 0; e < 30; e++) c_in_data[e*16 +: 16] = 16'h0100 + 16'(e);
        repeat (3) tick();
        s_axi_aresetn = 1'b1;
        tick();

        // Reset state
        check_eq("rst_out_valid", a_out_valid, 0);
        check_eq("rst_out_last", a_out_last, 0);
        check_eq("rst_out_data", a_out_data, 0);
        check_eq("rst_overflow", a_overflow, 0);
        check_eq("rst_drop_count", a_drop_count, 0);
        check_eq("rst_in_ready", a_in_ready, 1);

        // 1: single lane, always ready
        a_out_ready = 1; a_in_valid = 1; a_in_data = vec4(16'd4, 16'd3, 16'd2, 16'd1);
        tick();
        a_in_valid = 0;
        for (int k = 0; k < 4; k++) begin
            check_eq("t1_valid", a_out_valid, 1);
            check_eq("t1_data", a_out_data, 64'(k + 1));
            check_eq("t1_last", a_out_last, (k == 3) ? 1 : 0);
            tick();
        end
        check_eq("t1_no_extra_beat", a_out_valid, 0);

        // 2: two lanes
        b_out_ready = 1; b_in_valid = 1; b_in_data = vec4(16'hD, 16'hC, 16'hB, 16'hA);
        tick();
        b_in_valid = 0;
        check_eq("t2_b0_valid", b_out_valid, 1);
        check_eq("t2_b0_data", b_out_data, 64'h000B_000A);
        check_eq("t2_b0_last", b_out_last, 0);
        tick();
        check_eq("t2_b1_data", b_out_data, 64'h000D_000C);
        check_eq("t2_b1_last", b_out_last, 1);
        tick();
        check_eq("t2_done", b_out_valid, 0);

        // 4: 30 elements under a fixed irregular ready pattern
        c_in_valid = 1;
        tick();
        c_in_valid = 0;
        pat = 32'hB2E5_6D39;
        idx = 0;
        cyc = 0;
        while (idx < 30 && cyc < 300) begin
            c_out_ready = pat[cyc % 32];
            #1;
            exp_e = 16'h0100 + 16'(idx);
            check_eq("t4_valid", c_out_valid, 1);
            check_eq("t4_data", c_out_data, 64'(exp_e));
            check_eq("t4_last", c_out_last, (idx == 29) ? 1 : 0);
            if (c_out_ready) idx++;
            cyc++;
            tick();
        end
        check_eq("t4_beat_count", 64'(idx), 30);
        check_eq("t4_done", c_out_valid, 0);
        c_out_ready = 0;

        // 3: fill, drop, then drain back-to-back
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = V1;
        tick();
        a_in_data = V2;
        #1;
        check_eq("t3_ready_before_v2", a_in_ready, 1);
        tick();
        a_in_data = V3;
        #1;
        check_eq("t3_ready_full", a_in_ready, 0);
        tick();
        a_in_valid = 0;
        check_eq("t3_overflow", a_overflow, 1);
        check_eq("t3_drop_count", a_drop_count, 1);
        check_eq("t3_head_data", a_out_data, 16'h0011);
        a_out_ready = 1;
        for (int k = 0; k < 8; k++) begin
            exp_e = (k < 4) ? 16'h0011 + 16'(k) : 16'h0021 + 16'(k - 4);
            check_eq("t3_valid", a_out_valid, 1);
            check_eq("t3_data", a_out_data, 64'(exp_e));
            check_eq("t3_last", a_out_last, (k == 3 || k == 7) ? 1 : 0);
            tick();
        end
        check_eq("t3_done", a_out_valid, 0);

        // 5a: async reset mid-vector with a queued vector
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = V1;
        tick();
        a_in_data = V2;
        tick();
        a_in_valid = 0; a_out_ready = 1;
        tick();
        tick();
        check_eq("t5_mid_data", a_out_data, 16'h0013);
        s_axi_aresetn = 1'b0;
        #1;
        check_eq("t5_rst_valid", a_out_valid, 0);
        check_eq("t5_rst_last", a_out_last, 0);
        check_eq("t5_rst_data", a_out_data, 0);
        check_eq("t5_rst_overflow", a_overflow, 0);
        check_eq("t5_rst_drops", a_drop_count, 0);
        check_eq("t5_rst_in_ready", a_in_ready, 1);
        tick();
        s_axi_aresetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("t5_no_stale", a_out_valid, 0);
        end

        // 5b: soft reset mid-vector, effective at the next edge
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = V1;
        tick();
        a_in_data = V2;
        tick();
        a_in_data = V3;
        tick();
        a_in_valid = 0; a_out_ready = 1;
        tick();
        tick();
        check_eq("t5s_overflow_set", a_overflow, 1);
        check_eq("t5s_mid_data", a_out_data, 16'h0013);
        soft_reset = 1'b1;
        #1;
        check_eq("t5s_before_edge", a_out_valid, 1);
        tick();
        soft_reset = 1'b0;
        check_eq("t5s_valid", a_out_valid, 0);
        check_eq("t5s_data", a_out_data, 0);
        check_eq("t5s_last", a_out_last, 0);
        check_eq("t5s_overflow", a_overflow, 0);
        check_eq("t5s_drops", a_drop_count, 0);
        tick();
        check_eq("t5s_no_stale", a_out_valid, 0);

        // 6a: push on the pop cycle of a full buffer
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = V1;
        tick();
        a_in_data = V2;
        tick();
        a_in_valid = 0; a_out_ready = 1;
        repeat (3) tick();
        a_in_valid = 1; a_in_data = V3;
        #1;
        check_eq("t6_last_beat", a_out_last, 1);
        check_eq("t6_ready_on_pop", a_in_ready, 1);
        tick();
        a_in_valid = 0;
        check_eq("t6_no_drop", a_drop_count, 0);
        check_eq("t6_no_overflow", a_overflow, 0);
        for (int k = 0; k < 8; k++) begin
            exp_e = (k < 4) ? 16'h0021 + 16'(k) : 16'h0031 + 16'(k - 4);
            check_eq("t6_valid", a_out_valid, 1);
            check_eq("t6_data", a_out_data, 64'(exp_e));
            tick();
        end
        check_eq("t6_done", a_out_valid, 0);

        // 6b: drop counter saturation
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = V1;
        tick();
        a_in_data = V2;
        tick();
        a_in_data = V3;
        repeat (1000) tick();
        check_eq("t6_drops_1000", a_drop_count, 1000);
        repeat (65000) tick();
        a_in_valid = 0;
        check_eq("t6_drops_sat", a_drop_count, 16'hFFFF);
        check_eq("t6_sat_overflow", a_overflow, 1);
        check_eq("t6_buf_intact", a_out_data, 16'h0011);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
